// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port RAM arbiter: FSM states, port select
// values and the supported RAM read-latency range.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  // Wide enough to count up to the slowest supported RAM.
  localparam int WCNT_W     = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the CPU and DMA requests; on a tie
// the port that did not win last time is chosen.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic cpu_req_i,
  input  logic dma_req_i,
  input  logic last_winner_i,
  output logic pick_o
);

  always_comb begin
    pick_o = PORT_CPU;
    if (cpu_req_i && dma_req_i) begin
      pick_o = (last_winner_i == PORT_CPU) ? PORT_DMA : PORT_CPU;
    end else if (dma_req_i) begin
      pick_o = PORT_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for a CPU and a DMA/loader port, one transaction at a
// time. Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; default is CPU priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_done_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic              dma_gnt_o,
  output logic              dma_done_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              ram_we_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                we_q, we_d;
  logic                winner_q, winner_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                ram_we_q, ram_we_d;
  logic                cpu_gnt_q, cpu_gnt_d, dma_gnt_q, dma_gnt_d;
  logic                cpu_done_q, cpu_done_d, dma_done_q, dma_done_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic                last_winner, pick;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // The latched winner is updated only on ACCESS entry, so it is the last winner.
  assign last_winner = winner_q;
`else
  assign last_winner = PORT_DMA;
`endif

  mem_arb_pick u_pick (
    .cpu_req_i     (cpu_req_i),
    .dma_req_i     (dma_req_i),
    .last_winner_i (last_winner),
    .pick_o        (pick)
  );

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    we_d        = we_q;
    winner_d    = winner_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req_i || dma_req_i) begin
          state_d  = ACCESS;
          winner_d = pick;
          if (pick == PORT_DMA) begin
            we_d        = dma_we_i;
            ram_addr_d  = dma_addr_i;
            ram_wdata_d = dma_wdata_i;
          end else begin
            we_d        = cpu_we_i;
            ram_addr_d  = cpu_addr_i;
            ram_wdata_d = cpu_wdata_i;
          end
        end
      end
      ACCESS: begin
        wcnt_d = '0;
        if (we_q) begin
          state_d = DONE;
          // Writes report zero read data on their done pulse.
          if (winner_q == PORT_DMA) dma_rdata_d = '0;
          else                      cpu_rdata_d = '0;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wcnt_q == WCNT_W'(RD_LAT - 1)) begin
          state_d = DONE;
          wcnt_d  = '0;
          if (winner_q == PORT_DMA) dma_rdata_d = ram_rdata_i;
          else                      cpu_rdata_d = ram_rdata_i;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    cpu_gnt_d  = (state_d != IDLE) && (winner_d == PORT_CPU);
    dma_gnt_d  = (state_d != IDLE) && (winner_d == PORT_DMA);
    cpu_done_d = (state_d == DONE) && (winner_d == PORT_CPU);
    dma_done_d = (state_d == DONE) && (winner_d == PORT_DMA);
    ram_we_d   = (state_d == ACCESS) && we_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      we_q        <= 1'b0;
      winner_q    <= PORT_DMA;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      cpu_gnt_q   <= 1'b0;
      dma_gnt_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      dma_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      we_q        <= we_d;
      winner_q    <= winner_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      cpu_gnt_q   <= cpu_gnt_d;
      dma_gnt_q   <= dma_gnt_d;
      cpu_done_q  <= cpu_done_d;
      dma_done_q  <= dma_done_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign cpu_gnt_o   = cpu_gnt_q;
  assign dma_gnt_o   = dma_gnt_q;
  assign cpu_done_o  = cpu_done_q;
  assign dma_done_o  = dma_done_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dma_rdata_o = dma_rdata_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign ram_we_o    = ram_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance with RD_LAT=1 (index 0) and one with
// RD_LAT=4 (index 1), each behind its own RAM model, checked by a done scoreboard.
module tb_mem_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]    cpu_req, cpu_we, dma_req, dma_we;
  logic [1:0]    cpu_gnt, cpu_done, dma_gnt, dma_done, ram_we;
  logic [AW-1:0] cpu_addr [2];
  logic [AW-1:0] dma_addr [2];
  logic [AW-1:0] ram_addr [2];
  logic [DW-1:0] cpu_wdata [2];
  logic [DW-1:0] dma_wdata [2];
  logic [DW-1:0] cpu_rdata [2];
  logic [DW-1:0] dma_rdata [2];
  logic [DW-1:0] ram_wdata [2];
  logic [DW-1:0] rd0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req[0]), .cpu_we_i(cpu_we[0]), .cpu_addr_i(cpu_addr[0]), .cpu_wdata_i(cpu_wdata[0]),
    .cpu_gnt_o(cpu_gnt[0]), .cpu_done_o(cpu_done[0]), .cpu_rdata_o(cpu_rdata[0]),
    .dma_req_i(dma_req[0]), .dma_we_i(dma_we[0]), .dma_addr_i(dma_addr[0]), .dma_wdata_i(dma_wdata[0]),
    .dma_gnt_o(dma_gnt[0]), .dma_done_o(dma_done[0]), .dma_rdata_o(dma_rdata[0]),
    .ram_addr_o(ram_addr[0]), .ram_wdata_o(ram_wdata[0]), .ram_we_o(ram_we[0]), .ram_rdata_i(rd0)
  );

  logic [DW-1:0] pipe1 [4];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(4)) dut4 (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req[1]), .cpu_we_i(cpu_we[1]), .cpu_addr_i(cpu_addr[1]), .cpu_wdata_i(cpu_wdata[1]),
    .cpu_gnt_o(cpu_gnt[1]), .cpu_done_o(cpu_done[1]), .cpu_rdata_o(cpu_rdata[1]),
    .dma_req_i(dma_req[1]), .dma_we_i(dma_we[1]), .dma_addr_i(dma_addr[1]), .dma_wdata_i(dma_wdata[1]),
    .dma_gnt_o(dma_gnt[1]), .dma_done_o(dma_done[1]), .dma_rdata_o(dma_rdata[1]),
    .ram_addr_o(ram_addr[1]), .ram_wdata_o(ram_wdata[1]), .ram_we_o(ram_we[1]), .ram_rdata_i(pipe1[3])
  );

  // RAM models: latency 1 for dut1, a 4-deep read pipeline for dut4.
  logic          ram_init = 1'b0;
  logic [DW-1:0] mem0 [512];
  logic [DW-1:0] mem1 [512];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 512; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
      mem0[5] <= 32'hDEADBEEF;
      mem1[5] <= 32'hDEADBEEF;
    end else begin
      if (ram_we[0]) mem0[ram_addr[0]] <= ram_wdata[0];
      if (ram_we[1]) mem1[ram_addr[1]] <= ram_wdata[1];
    end
    rd0      <= mem0[ram_addr[0]];
    pipe1[0] <= mem1[ram_addr[1]];
    for (int i = 1; i < 4; i++) pipe1[i] <= pipe1[i-1];
  end

  typedef struct {
    logic          port;
    logic [DW-1:0] rdata;
    int            start;
    int            lat;
  } sb_t;
  sb_t q0[$];
  sb_t q1[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string nm, int d, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", nm, d, act, exp, cyc);
    end
  endtask

  // Scoreboard: every done pulse pops one expectation.
  logic [1:0] prev_we = 2'b00;
  always @(negedge clk) begin
    sb_t e;
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        chk("gnt_exclusive", d, cpu_gnt[d] & dma_gnt[d], 0);
        chk("ram_we_one_clock", d, ram_we[d] & prev_we[d], 0);
        if (cpu_done[d] | dma_done[d]) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            chk("unexpected_done", d, cpu_done[d] | dma_done[d], 0);
          end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk("done_port", d, dma_done[d], e.port);
            chk("both_done", d, cpu_done[d] & dma_done[d], 0);
            chk("rdata", d, e.port ? dma_rdata[d] : cpu_rdata[d], e.rdata);
            chk("latency", d, cyc - e.start, e.lat);
            chk("winner_gnt", d, e.port ? dma_gnt[d] : cpu_gnt[d], 1);
            chk("loser_gnt", d, e.port ? cpu_gnt[d] : dma_gnt[d], 0);
          end
        end
      end
    end
    prev_we <= ram_we;
  end

  task automatic drive(int d, logic port, logic we, logic [AW-1:0] a, logic [DW-1:0] wd);
    if (port) begin
      dma_req[d] = 1'b1; dma_we[d] = we; dma_addr[d] = a; dma_wdata[d] = wd;
    end else begin
      cpu_req[d] = 1'b1; cpu_we[d] = we; cpu_addr[d] = a; cpu_wdata[d] = wd;
    end
  endtask

  task automatic expect_txn(int d, logic port, logic [DW-1:0] rd, int start, int lat);
    sb_t e;
    e.port = port; e.rdata = rd; e.start = start; e.lat = lat;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Wait (bounded) for all expected dones, then drop requests in the IDLE clock.
  task automatic wait_drain(int d);
    int k = 0;
    while ((d == 0 ? q0.size() : q1.size()) != 0 && k < 60) begin
      @(negedge clk); #1;
      k++;
    end
    chk("drain_timeout", d, d == 0 ? q0.size() : q1.size(), 0);
    if (d == 0) q0.delete();
    else        q1.delete();
    @(posedge clk); #1;
    cpu_req[d] = 1'b0;
    dma_req[d] = 1'b0;
  endtask

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int c0;
    tbl[0] = '{1'b1, 1'b1, 9'h1FF, 32'h12345678, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 9'h005, 32'h0,        32'hDEADBEEF};
    tbl[2] = '{1'b0, 1'b0, 9'h1FF, 32'h0,        32'h12345678};
    tbl[3] = '{1'b0, 1'b1, 9'h00A, 32'hA5A5A5A5, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 9'h00A, 32'h0,        32'hA5A5A5A5};
    tbl[5] = '{1'b1, 1'b1, 9'h000, 32'hFFFFFFFF, 32'h0};
    tbl[6] = '{1'b0, 1'b0, 9'h000, 32'h0,        32'hFFFFFFFF};
    tbl[7] = '{1'b1, 1'b0, 9'h005, 32'h0,        32'hDEADBEEF};

    cpu_req = '0; cpu_we = '0; dma_req = '0; dma_we = '0;
    for (int d = 0; d < 2; d++) begin
      cpu_addr[d] = '0; dma_addr[d] = '0; cpu_wdata[d] = '0; dma_wdata[d] = '0;
    end
    rst = 1'b1;
    ram_init = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ram_init = 1'b0;

    for (int d = 0; d < 2; d++) begin
      chk("rst_cpu_gnt", d, cpu_gnt[d], 0);
      chk("rst_dma_gnt", d, dma_gnt[d], 0);
      chk("rst_cpu_done", d, cpu_done[d], 0);
      chk("rst_dma_done", d, dma_done[d], 0);
      chk("rst_ram_we", d, ram_we[d], 0);
      chk("rst_ram_addr", d, ram_addr[d], 0);
      chk("rst_ram_wdata", d, ram_wdata[d], 0);
      chk("rst_cpu_rdata", d, cpu_rdata[d], 0);
      chk("rst_dma_rdata", d, dma_rdata[d], 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Single transactions on the RD_LAT=1 instance.
    for (int i = 0; i < 8; i++) begin
      drive(0, tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      expect_txn(0, tbl[i].port, tbl[i].exp, cyc, tbl[i].we ? 2 : 3);
      wait_drain(0);
    end
    chk("cpu_rdata_hold", 0, cpu_rdata[0], 32'hFFFFFFFF);

    // Both ports held: alternation with round-robin, CPU every time without.
    drive(0, 1'b0, 1'b1, 9'h100, 32'h11111111);
    drive(0, 1'b1, 1'b1, 9'h101, 32'h22222222);
    c0 = cyc;
    for (int k = 0; k < 4; k++)
      expect_txn(0, RR ? k[0] : 1'b0, 32'h0, c0 + 3 * k, 2);
    wait_drain(0);

    // Reset during WAIT of a CPU read on the RD_LAT=4 instance.
    drive(1, 1'b0, 1'b0, 9'h005, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    chk("pre_rst_cpu_gnt", 1, cpu_gnt[1], 1);
    rst = 1'b1;
    #1;
    chk("arst_cpu_gnt", 1, cpu_gnt[1], 0);
    chk("arst_dma_gnt", 1, dma_gnt[1], 0);
    chk("arst_cpu_done", 1, cpu_done[1], 0);
    chk("arst_ram_we", 1, ram_we[1], 0);
    chk("arst_ram_addr", 1, ram_addr[1], 0);
    chk("arst_cpu_rdata", 1, cpu_rdata[1], 0);
    cpu_req[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // First tie after reset goes to the CPU.
    drive(1, 1'b0, 1'b1, 9'h010, 32'hCAFE0001);
    drive(1, 1'b1, 1'b1, 9'h011, 32'hCAFE0002);
    expect_txn(1, 1'b0, 32'h0, cyc, 2);
    wait_drain(1);

    // Request dropped and address changed mid-read: original address completes.
    drive(1, 1'b0, 1'b0, 9'h005, 32'h0);
    expect_txn(1, 1'b0, 32'hDEADBEEF, cyc, 6);
    @(posedge clk); @(posedge clk); #1;
    cpu_req[1]  = 1'b0;
    cpu_addr[1] = 9'h1FF;
    wait_drain(1);

    // Back-to-back reads held high: one IDLE clock between transactions.
    drive(1, 1'b0, 1'b0, 9'h005, 32'h0);
    c0 = cyc;
    expect_txn(1, 1'b0, 32'hDEADBEEF, c0, 6);
    expect_txn(1, 1'b0, 32'hDEADBEEF, c0 + 7, 6);
    wait_drain(1);

    // DMA read of data the CPU wrote earlier, through the 4-clock RAM.
    drive(1, 1'b1, 1'b0, 9'h010, 32'h0);
    expect_txn(1, 1'b1, 32'hCAFE0001, cyc, 6);
    wait_drain(1);

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
